mips_data_memory: RTL and testbench
===================================

# mips_data_memory

Data-memory responder for the single-cycle MIPS core: accepts the core's data-memory address, write-enable and write-data, returns read data combinationally in the same cycle, and commits stores on the rising clock edge. After every reset it runs a self-clear sequence that zeroes the array one word per cycle, then reports ready. Misaligned or not-ready stores are rejected and flagged so the bench and core can detect protocol violations.

## Interface

- ADDR_W, 6, word-index width; DEPTH = 2**ADDR_W words of 32 bits
- clk  input  1  clock, all state changes on rising edge
- reset  input  1  synchronous, active-high
- data_memory_a  input  32  byte address from core
- data_memory_we  input  1  store request
- data_memory_wd  input  32  store data
- data_memory_rd  output  32  load data (combinational)
- mem_ready  output  1  clear sequence finished, stores accepted
- mem_misaligned_err  output  1  sticky: a store with a[1:0] != 0 was seen
- mem_write_count  output  32  accepted stores (only with MIPS_MEM_STATS_EN)
- mem_reject_count  output  32  rejected stores (only with MIPS_MEM_STATS_EN)

## Operation

- Index = data_memory_a[ADDR_W+1:2]; bits above ADDR_W+1 ignored (address wraps modulo DEPTH*4).
- Read: data_memory_rd = array[index] whenever mem_ready=1; forced to 32'h0 while mem_ready=0. Byte bits a[1:0] ignored on reads; reads never set error.
- FSM states: CLEAR, READY.
  - reset=1 -> state CLEAR, clear index 0, mem_ready=0, mem_misaligned_err=0, counters 0.
  - CLEAR: each cycle write 0 to array[clr_idx], clr_idx++. At clr_idx = DEPTH-1 the final zero is written and next state is READY.
  - READY: remains until reset.
- Store accepted iff state READY, data_memory_we=1, a[1:0]=0: array[index] <= data_memory_wd at clock edge.
- Store rejected if we=1 and (state CLEAR or a[1:0] != 0): no array change. Misalignment sets mem_misaligned_err (sticky until reset), regardless of state. Not-ready rejection alone does not set error.
- Counters saturate at 32'hFFFF_FFFF.

## Timing

- Load latency 0 cycles (combinational from data_memory_a).
- Store visible on data_memory_rd the cycle after the accepting edge; read of the same address in the store cycle returns the old value (no bypass; matches single-cycle core semantics).
- Clear takes exactly DEPTH cycles after reset deasserts; mem_ready rises at the edge ending cycle DEPTH (DEPTH=64: cycle 64 after reset low).
- Reset asserted mid-clear restarts clear from index 0; reset in READY re-clears whole array.
- Error flag and counters update at the same edge as the store decision.

## Configuration

- MIPS_MEM_STATS_EN defined: mem_write_count and mem_reject_count ports and counter registers exist, reset to 0, update as above.
- Not defined: ports absent, no counter logic; all other behaviour identical.

## Structure

- Shared package/include mips_defs: state encoding constants (MEM_CLEAR, MEM_READY), word width 32, default ADDR_W.
- One sub-module: mips_mem_clear_seq (counter + FSM; outputs clr_we, clr_idx, ready). Top holds array, accept/reject logic, error flag, optional counters.

## Test plan

- Reset 1 cycle, ADDR_W=6 -> mem_ready=0 for 64 cycles, rises after cycle 64; data_memory_rd=0 throughout; every address reads 0 after ready.
- Preload garbage via stores, reset again -> all 64 words read 0 after re-clear; reset at clear cycle 30 -> ready only 64 cycles after that reset.
- READY, store 0xDEADBEEF to a=0x10 -> same cycle rd at 0x10 old value 0; next cycle 0xDEADBEEF; read a=0x110 (wrap, index 4) -> 0xDEADBEEF.
- Store 0x12345678 to a=0x12 -> array unchanged, mem_misaligned_err=1 and stays 1 until reset; mem_reject_count=1.
- Store during CLEAR to a=0x8 -> no write, error stays 0, reject_count increments; after ready a=0x8 reads 0.
- With MIPS_MEM_STATS_EN: 5 accepted stores, 2 rejected -> write_count=5, reject_count=2; forced counter at 32'hFFFF_FFFF stays saturated.

Source files
------------

// File: rtl/mips_data_memory_pkg.sv
// mips_data_memory_pkg: shared word width, default depth, clear-FSM state encoding.
package mips_data_memory_pkg;
    localparam int WORD_W = 32;
    localparam int DEF_ADDR_W = 6;
    typedef enum logic {MEM_CLEAR = 1'b0, MEM_READY = 1'b1} mem_state_t;
    function automatic logic [WORD_W-1:0] sat_inc(input logic [WORD_W-1:0] v);
        return &v ? v : v + 1'b1;
    endfunction
endpackage

// File: rtl/mips_data_memory_if.sv
// mips_data_memory_if: core <-> data memory bus; statistics signals exist only with MIPS_MEM_STATS_EN.
interface mips_data_memory_if;
    import mips_data_memory_pkg::*;
    logic [WORD_W-1:0] data_memory_a;
    logic              data_memory_we;
    logic [WORD_W-1:0] data_memory_wd;
    logic [WORD_W-1:0] data_memory_rd;
    logic              mem_ready;
    logic              mem_misaligned_err;
`ifdef MIPS_MEM_STATS_EN
    logic [WORD_W-1:0] mem_write_count;
    logic [WORD_W-1:0] mem_reject_count;
    modport master(output data_memory_a, data_memory_we, data_memory_wd,
                   input data_memory_rd, mem_ready, mem_misaligned_err, mem_write_count, mem_reject_count);
    modport slave(input data_memory_a, data_memory_we, data_memory_wd,
                  output data_memory_rd, mem_ready, mem_misaligned_err, mem_write_count, mem_reject_count);
`else
    modport master(output data_memory_a, data_memory_we, data_memory_wd,
                   input data_memory_rd, mem_ready, mem_misaligned_err);
    modport slave(input data_memory_a, data_memory_we, data_memory_wd,
                  output data_memory_rd, mem_ready, mem_misaligned_err);
`endif
endinterface

// File: rtl/mips_mem_clear_seq.sv
// mips_mem_clear_seq: post-reset sweep that zeroes one word per cycle, then holds ready.
module mips_mem_clear_seq
    import mips_data_memory_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_idx,
    output logic              ready
);
    mem_state_t state;
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= MEM_CLEAR;
            clr_idx <= '0;
            clr_we  <= 1'b1;
            ready   <= 1'b0;
        end else if (state == MEM_CLEAR) begin
            clr_idx <= clr_idx + ADDR_W'(1);
            if (&clr_idx) begin
                state  <= MEM_READY;
                clr_we <= 1'b0;
                ready  <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/mips_data_memory.sv
// mips_data_memory: single-cycle MIPS data memory with self-clear; optional counters via MIPS_MEM_STATS_EN.
module mips_data_memory
    import mips_data_memory_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input logic               clk,
    input logic               reset,
    mips_data_memory_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    logic [WORD_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] idx, clr_idx;
    logic              clr_we, ready, mis, accept, err, unused_hi;
    assign idx       = bus.data_memory_a[ADDR_W+1:2];
    assign mis       = bus.data_memory_we && (bus.data_memory_a[1:0] != 2'b00);
    assign accept    = ready && bus.data_memory_we && !mis;
    assign unused_hi = &{1'b0, bus.data_memory_a[WORD_W-1:ADDR_W+2]};
    mips_mem_clear_seq #(.ADDR_W(ADDR_W)) u_clr (
        .clk    (clk),
        .reset  (reset),
        .clr_we (clr_we),
        .clr_idx(clr_idx),
        .ready  (ready)
    );
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (clr_we) mem[clr_idx] <= '0;
            else if (accept) mem[idx] <= bus.data_memory_wd;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) err <= 1'b0;
        else if (mis) err <= 1'b1;
    end
    assign bus.data_memory_rd     = ready ? mem[idx] : '0;
    assign bus.mem_ready          = ready;
    assign bus.mem_misaligned_err = err;
`ifdef MIPS_MEM_STATS_EN
    logic [WORD_W-1:0] write_count, reject_count;
    always_ff @(posedge clk) begin
        if (reset) begin
            write_count  <= '0;
            reject_count <= '0;
        end else if (accept) begin
            write_count  <= sat_inc(write_count);
        end else if (bus.data_memory_we) begin
            reject_count <= sat_inc(reject_count);
        end
    end
    assign bus.mem_write_count  = write_count;
    assign bus.mem_reject_count = reject_count;
`endif
endmodule

// File: tb/tb_mips_data_memory.sv
// tb_mips_data_memory: table vectors, hand sequences and random traffic against a word-array model.
module tb_mips_data_memory;
    logic clk = 1'b0;
    logic reset;
    int   n_pass = 0;
    int   n_total = 0;
    mips_data_memory_if bus();
    mips_data_memory dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;

    logic [31:0] mdl_mem [64];
    int          cyc;
    bit          m_err;
    logic [31:0] m_wc, m_rc;

    typedef struct {
        logic [31:0] a;
        logic        we;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;
    vec_t tbl [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] exp_rd(input logic [31:0] a);
        return (cyc >= 64) ? mdl_mem[(a / 4) % 64] : 32'h0;
    endfunction

    // Drive at negedge, check combinational outputs 1ns later, then let the model follow the edge.
    task automatic cycle(input bit r, input logic [31:0] a, input bit we, input logic [31:0] wd,
                         output logic [31:0] rd_s, output logic err_s);
        reset = r;
        bus.data_memory_a = a;
        bus.data_memory_we = we;
        bus.data_memory_wd = wd;
        #1;
        rd_s = bus.data_memory_rd;
        err_s = bus.mem_misaligned_err;
        if (!r) begin
            check("rd", bus.data_memory_rd, exp_rd(a));
            check("ready", 32'(bus.mem_ready), 32'(cyc >= 64));
            check("err", 32'(bus.mem_misaligned_err), 32'(m_err));
`ifdef MIPS_MEM_STATS_EN
            check("write_count", bus.mem_write_count, m_wc);
            check("reject_count", bus.mem_reject_count, m_rc);
`endif
        end
        @(posedge clk);
        if (r) begin
            foreach (mdl_mem[i]) mdl_mem[i] = 32'h0;
            cyc = 0;
            m_err = 0;
            m_wc = 0;
            m_rc = 0;
        end else begin
            if (we && (a % 4) != 0) m_err = 1;
            if (we && cyc >= 64 && (a % 4) == 0) begin
                mdl_mem[(a / 4) % 64] = wd;
                if (m_wc != 32'hFFFF_FFFF) m_wc++;
            end else if (we && m_rc != 32'hFFFF_FFFF) begin
                m_rc++;
            end
            if (cyc < 64) cyc++;
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic [31:0] a);
        logic [31:0] rd_s;
        logic        err_s;
        cycle(0, a, 0, 32'h0, rd_s, err_s);
    endtask

    task automatic do_reset();
        logic [31:0] rd_s;
        logic        err_s;
        cycle(1, 32'h0, 0, 32'h0, rd_s, err_s);
    endtask

    // Exactly 64 not-ready cycles, then ready must be high.
    task automatic clear_run(input string name);
        int early = 0;
        for (int i = 0; i < 64; i++) begin
            reset = 0;
            #0;
            if (bus.mem_ready) early++;
            idle($urandom);
        end
        check({name, "_early_ready"}, 32'(early), 32'd0);
        check({name, "_ready"}, 32'(bus.mem_ready), 32'd1);
    endtask

    task automatic read_all_zero(input string name);
        int nz = 0;
        for (int i = 0; i < 64; i++) begin
            bus.data_memory_a = 32'(i * 4);
            bus.data_memory_we = 0;
            #1;
            if (bus.data_memory_rd != 32'h0) nz++;
            idle(32'(i * 4));
        end
        check({name, "_nonzero_words"}, 32'(nz), 32'd0);
    endtask

    initial begin
        logic [31:0] rd_s;
        logic        err_s;
        tbl[0] = '{32'h010, 1, 32'hDEAD_BEEF, 32'h0, 0};
        tbl[1] = '{32'h010, 0, 32'h0, 32'hDEAD_BEEF, 0};
        tbl[2] = '{32'h110, 0, 32'h0, 32'hDEAD_BEEF, 0};
        tbl[3] = '{32'h012, 1, 32'h1234_5678, 32'hDEAD_BEEF, 0};
        tbl[4] = '{32'h010, 0, 32'h0, 32'hDEAD_BEEF, 1};
        tbl[5] = '{32'h013, 0, 32'h0, 32'hDEAD_BEEF, 1};
        tbl[6] = '{32'h0FC, 1, 32'hA5A5_A5A5, 32'h0, 1};
        tbl[7] = '{32'h3FC, 0, 32'h0, 32'hA5A5_A5A5, 1};
        tbl[8] = '{32'h000, 0, 32'h0, 32'h0, 1};

        do_reset();
        clear_run("first_clear");
        read_all_zero("first_clear");

        foreach (tbl[i]) begin
            cycle(0, tbl[i].a, tbl[i].we, tbl[i].wd, rd_s, err_s);
            check($sformatf("tbl%0d_rd", i), rd_s, tbl[i].exp_rd);
            check($sformatf("tbl%0d_err", i), 32'(err_s), 32'(tbl[i].exp_err));
        end
`ifdef MIPS_MEM_STATS_EN
        check("tbl_write_count", bus.mem_write_count, 32'd2);
        check("tbl_reject_count", bus.mem_reject_count, 32'd1);
`endif

        for (int i = 0; i < 64; i++) cycle(0, 32'(i * 4), 1, $urandom | 32'h1, rd_s, err_s);
        do_reset();
        check("err_cleared_by_reset", 32'(bus.mem_misaligned_err), 32'd0);
        clear_run("reclear");
        read_all_zero("reclear");

        do_reset();
        for (int i = 0; i < 30; i++) idle($urandom);
        do_reset();
        clear_run("midclear_reset");

        do_reset();
        for (int i = 0; i < 10; i++) idle($urandom);
        cycle(0, 32'h8, 1, 32'hFFFF_FFFF, rd_s, err_s);
        for (int i = 0; i < 53; i++) idle(32'h4);
        check("clear_store_ready", 32'(bus.mem_ready), 32'd1);
        check("clear_store_err", 32'(bus.mem_misaligned_err), 32'd0);
        cycle(0, 32'h8, 0, 32'h0, rd_s, err_s);
        check("clear_store_word", rd_s, 32'h0);
`ifdef MIPS_MEM_STATS_EN
        check("clear_store_rejects", bus.mem_reject_count, 32'd1);
        do_reset();
        for (int i = 0; i < 64; i++) idle(32'h0);
        for (int i = 0; i < 5; i++) cycle(0, 32'(i * 8), 1, 32'(i + 1), rd_s, err_s);
        cycle(0, 32'h21, 1, 32'h1, rd_s, err_s);
        cycle(0, 32'h22, 1, 32'h1, rd_s, err_s);
        check("stats_writes", bus.mem_write_count, 32'd5);
        check("stats_rejects", bus.mem_reject_count, 32'd2);
        dut.write_count = 32'hFFFF_FFFF;
        dut.reject_count = 32'hFFFF_FFFF;
        m_wc = 32'hFFFF_FFFF;
        m_rc = 32'hFFFF_FFFF;
        cycle(0, 32'h40, 1, 32'h7, rd_s, err_s);
        cycle(0, 32'h41, 1, 32'h7, rd_s, err_s);
        check("sat_writes", bus.mem_write_count, 32'hFFFF_FFFF);
        check("sat_rejects", bus.mem_reject_count, 32'hFFFF_FFFF);
`endif

        for (int i = 0; i < 600; i++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & 32'hFFFF_FFFC;
            cycle($urandom_range(0, 99) == 0, a, 1'($urandom_range(0, 1)), $urandom, rd_s, err_s);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
